simon_stream_feeder: RTL and testbench

Stream front end for the 128/256 Simon core (`simon`). Accepts plaintext or ciphertext as a 32-bit valid/ready word stream, packs four words into a 128-bit block, and runs the core's reset/start/done sequence once per block. It then returns the core result as a 32-bit valid/ready word stream. Optional CBC chaining sits around the core in this block, so the core itself remains a pure single-block ECB engine.

---
 rtl/simon_pkg.sv | 22 ++
 rtl/simon_word_shreg.sv | 39 +++
 rtl/simon_stream_feeder.sv | 172 +++++++++++++++++
 tb/tb_simon_stream_feeder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
`default_nettype none
// simon_pkg: shared widths and FSM state encoding for the Simon stream feeder. Rev 1.0
package simon_pkg;

   localparam int SIMON_BLOCK_W = 128;
   localparam int SIMON_KEY_W   = 256;
   localparam int SIMON_WORD_W  = 32;
   localparam int SIMON_WORDS   = 4;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } simon_feed_state_t;

   function automatic logic [SIMON_WORD_W-1:0] simon_top_word(input logic [SIMON_BLOCK_W-1:0] blk);
      return blk[SIMON_BLOCK_W-1 -: SIMON_WORD_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/simon_word_shreg.sv
`default_nettype none
// simon_word_shreg: 4x32 block register with parallel load and word-wise left shift. Rev 1.0
module simon_word_shreg
   import simon_pkg::*;
(
   input  logic                     clk,
   input  logic                     res,
   input  logic                     load_i,
   input  logic [SIMON_BLOCK_W-1:0] load_data_i,
   input  logic                     shift_i,
   input  logic [SIMON_WORD_W-1:0]  shift_data_i,
   output logic [SIMON_BLOCK_W-1:0] data_o
);

   logic [SIMON_BLOCK_W-1:0] data_q;
   logic [SIMON_BLOCK_W-1:0] data_d;

   // Load wins over shift; a shift moves the next word into the top slot.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         data_d = {data_q[SIMON_BLOCK_W-SIMON_WORD_W-1:0], shift_data_i};
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/simon_stream_feeder.sv
`default_nettype none
// simon_stream_feeder: 32-bit word stream front end around the Simon 128/256 core.
// Build macro SIMON_CBC_EN adds CBC chaining around the core. Rev 1.0
module simon_stream_feeder
   import simon_pkg::*;
(
   input  logic                     clk,
   input  logic                     res,
   input  logic                     cfg_load,
   input  logic [SIMON_KEY_W-1:0]   cfg_key,
   input  logic                     cfg_dec,
   input  logic [SIMON_BLOCK_W-1:0] cfg_iv,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIMON_WORD_W-1:0]  in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIMON_WORD_W-1:0]  out_data,
   output logic                     busy,
   output logic                     core_res_n,
   output logic                     core_start,
   output logic                     core_ctrl,
   output logic [SIMON_KEY_W-1:0]   core_keys,
   output logic [SIMON_BLOCK_W-1:0] core_in,
   input  logic [SIMON_BLOCK_W-1:0] core_out,
   input  logic                     core_done
);

   simon_feed_state_t        state_q;
   logic [1:0]               cnt_q;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic                     busy_q;
   logic                     core_res_n_q;
   logic                     core_start_q;
   logic [SIMON_KEY_W-1:0]   key_q;
   logic                     dec_q;

   logic [SIMON_BLOCK_W-1:0] in_blk;
   logic [SIMON_BLOCK_W-1:0] out_blk;
   logic [SIMON_BLOCK_W-1:0] core_in_d;
   logic [SIMON_BLOCK_W-1:0] capture_d;
   logic                     last_word;
   logic                     in_shift;
   logic                     out_shift;
   logic                     cfg_accept;
   logic                     capture;
   logic                     unused_out_low;

   assign last_word  = (cnt_q == 2'(SIMON_WORDS - 1));
   assign in_shift   = (state_q == ST_LOAD) && in_valid;
   assign out_shift  = (state_q == ST_DRAIN) && out_ready;
   assign cfg_accept = (state_q == ST_LOAD) && (cnt_q == 2'd0) && cfg_load;
   assign capture    = (state_q == ST_WAIT) && core_done;

   // Outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q      <= ST_LOAD;
         cnt_q        <= 2'd0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         core_res_n_q <= 1'b0;
         core_start_q <= 1'b0;
         key_q        <= '0;
         dec_q        <= 1'b0;
      end else begin
         if (cfg_accept) begin
            key_q <= cfg_key;
            dec_q <= cfg_dec;
         end
         case (state_q)
            ST_LOAD: begin
               if (in_valid) begin
                  cnt_q  <= cnt_q + 2'd1;
                  busy_q <= 1'b1;
                  if (last_word) begin
                     state_q      <= ST_START;
                     in_ready_q   <= 1'b0;
                     core_res_n_q <= 1'b1;
                     core_start_q <= 1'b1;
                  end
               end
            end
            ST_START: begin
               state_q      <= ST_WAIT;
               core_start_q <= 1'b0;
            end
            ST_WAIT: begin
               if (core_done) begin
                  state_q      <= ST_DRAIN;
                  core_res_n_q <= 1'b0;
                  out_valid_q  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  cnt_q <= cnt_q + 2'd1;
                  if (last_word) begin
                     state_q     <= ST_LOAD;
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     busy_q      <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_LOAD;
            end
         endcase
      end
   end

`ifdef SIMON_CBC_EN
   logic [SIMON_BLOCK_W-1:0] chain_q;

   // Chain always follows the ciphertext side: core output when encrypting, input when decrypting.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         chain_q <= '0;
      end else if (cfg_accept) begin
         chain_q <= cfg_iv;
      end else if (capture) begin
         chain_q <= dec_q ? in_blk : core_out;
      end
   end

   assign core_in_d = dec_q ? in_blk : (in_blk ^ chain_q);
   assign capture_d = dec_q ? (core_out ^ chain_q) : core_out;
`else
   logic unused_iv;

   assign unused_iv = ^cfg_iv;
   assign core_in_d = in_blk;
   assign capture_d = core_out;
`endif

   simon_word_shreg u_in_shreg (
      .clk          (clk),
      .res          (res),
      .load_i       (1'b0),
      .load_data_i  ({SIMON_BLOCK_W{1'b0}}),
      .shift_i      (in_shift),
      .shift_data_i (in_data),
      .data_o       (in_blk)
   );

   simon_word_shreg u_out_shreg (
      .clk          (clk),
      .res          (res),
      .load_i       (capture),
      .load_data_i  (capture_d),
      .shift_i      (out_shift),
      .shift_data_i ({SIMON_WORD_W{1'b0}}),
      .data_o       (out_blk)
   );

   assign unused_out_low = ^out_blk[SIMON_BLOCK_W-SIMON_WORD_W-1:0];

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = simon_top_word(out_blk);
   assign busy       = busy_q;
   assign core_res_n = core_res_n_q;
   assign core_start = core_start_q;
   assign core_ctrl  = dec_q;
   assign core_keys  = key_q;
   assign core_in    = core_in_d;

endmodule
`default_nettype wire

// File: tb/tb_simon_stream_feeder.sv
`default_nettype none
// tb_simon_stream_feeder: randomized scoreboard bench; the core is a stub computing in ^ key[127:0]
// after a random latency, so encrypt and decrypt are the same function.
module tb_simon_stream_feeder;
   import simon_pkg::*;

   logic         clk = 1'b0;
   logic         res = 1'b1;
   logic         cfg_load = 1'b0;
   logic [255:0] cfg_key = '0;
   logic         cfg_dec = 1'b0;
   logic [127:0] cfg_iv = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic         busy;
   logic         core_res_n;
   logic         core_start;
   logic         core_ctrl;
   logic [255:0] core_keys;
   logic [127:0] core_in;
   logic [127:0] core_out = '0;
   logic         core_done = 1'b0;

   always #5 clk = ~clk;

   simon_stream_feeder dut (
      .clk        (clk),
      .res        (res),
      .cfg_load   (cfg_load),
      .cfg_key    (cfg_key),
      .cfg_dec    (cfg_dec),
      .cfg_iv     (cfg_iv),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .core_res_n (core_res_n),
      .core_start (core_start),
      .core_ctrl  (core_ctrl),
      .core_keys  (core_keys),
      .core_in    (core_in),
      .core_out   (core_out),
      .core_done  (core_done)
   );

   // Stub core: done is a level that stays high until core_res_n drops.
   int           stub_cnt = 0;
   logic         stub_run = 1'b0;
   logic [127:0] stub_blk = '0;
   always @(posedge clk or negedge core_res_n) begin
      if (!core_res_n) begin
         core_done <= 1'b0;
         core_out  <= '0;
         stub_run  <= 1'b0;
         stub_cnt  <= 0;
      end else if (core_start) begin
         stub_run <= 1'b1;
         stub_cnt <= int'($urandom_range(1, 5));
         stub_blk <= core_in;
      end else if (stub_run) begin
         if (stub_cnt <= 1) begin
            core_done <= 1'b1;
            core_out  <= stub_blk ^ core_keys[127:0];
            stub_run  <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   int           total = 0;
   int           bad = 0;
   logic [31:0]  exp_q[$];
   logic [255:0] m_key = '0;
   logic         m_dec = 1'b0;
   logic [127:0] m_chain = '0;
   logic         chk_en = 1'b0;
   int           or_mode = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] rnd256();
      return {rnd128(), rnd128()};
   endfunction

   // Reference model: single-block cipher E(x) = D(x) = x ^ key[127:0], chained per CBC when built.
   task automatic push_expected(input logic [127:0] p);
      logic [127:0] r;
`ifdef SIMON_CBC_EN
      if (m_dec) begin
         r       = (p ^ m_key[127:0]) ^ m_chain;
         m_chain = p;
      end else begin
         r       = (p ^ m_chain) ^ m_key[127:0];
         m_chain = r;
      end
`else
      r = p ^ m_key[127:0];
`endif
      for (int i = 0; i < 4; i++) exp_q.push_back(r[127-32*i -: 32]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic cl, input logic [255:0] k,
                            input logic d, input logic [127:0] iv);
      int   guard;
      logic rdy;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = w;
      cfg_load = cl;
      if (cl) begin
         cfg_key = k;
         cfg_dec = d;
         cfg_iv  = iv;
      end
      do begin
         rdy = in_ready;
         tick();
         guard++;
      end while (!rdy && guard < 300);
      if (!rdy) tmo("in_handshake");
      in_valid = 1'b0;
      cfg_load = 1'b0;
   endtask

   // cfg_mode: 0 none, 1 config latched with the first word, 2 config pulse mid-block (must be ignored)
   task automatic send_block(input logic [127:0] p, input int cfg_mode);
      logic [255:0] k;
      logic         d;
      logic [127:0] iv;
      k  = rnd256();
      d  = 1'($urandom % 2);
      iv = rnd128();
      if (cfg_mode == 1) begin
         m_key   = k;
         m_dec   = d;
         m_chain = iv;
      end
      push_expected(p);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_word(p[127-32*i -: 32], (cfg_mode == 1 && i == 0) || (cfg_mode == 2 && i == 2), k, d, iv);
      end
   endtask

   task automatic load_cfg(input logic [255:0] k, input logic d, input logic [127:0] iv);
      int guard;
      guard = 0;
      while (busy && guard < 300) begin
         tick();
         guard++;
      end
      if (busy) tmo("idle_before_cfg");
      cfg_load = 1'b1;
      cfg_key  = k;
      cfg_dec  = d;
      cfg_iv   = iv;
      m_key    = k;
      m_dec    = d;
      m_chain  = iv;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 3000) begin
         tick();
         guard++;
      end
      if (exp_q.size() != 0 || busy) tmo("drain");
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},   256'(in_ready), 256'(1));
      chk({tag, "_out_valid"},  256'(out_valid), 256'(0));
      chk({tag, "_busy"},       256'(busy), 256'(0));
      chk({tag, "_core_res_n"}, 256'(core_res_n), 256'(0));
      chk({tag, "_core_start"}, 256'(core_start), 256'(0));
      chk({tag, "_core_ctrl"},  256'(core_ctrl), 256'(0));
      chk({tag, "_core_keys"},  core_keys, 256'(0));
      chk({tag, "_core_in"},    256'(core_in), 256'(0));
      chk({tag, "_out_data"},   256'(out_data), 256'(0));
   endtask

   // Output scoreboard monitor.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (chk_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_unexpected: got %h expected none", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 256'(out_data), 256'(e));
            end
         end
      end
   end

   // Cycle-level protocol checks against the bench's own word count.
   initial begin
      int   wcnt;
      logic exp_start;
      logic done_pend;
      wcnt = 0;
      exp_start = 1'b0;
      done_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (!chk_en) begin
            wcnt      = 0;
            exp_start = 1'b0;
            done_pend = 1'b0;
         end else begin
            chk("core_start", 256'(core_start), 256'(exp_start));
            if (done_pend) chk("out_valid_after_done", 256'(out_valid), 256'(1));
            if (in_ready) chk("core_res_n_in_load", 256'(core_res_n), 256'(0));
            chk("busy", 256'(busy), 256'(!(in_ready && wcnt == 0)));
            exp_start = in_valid && in_ready && (wcnt == 3);
            done_pend = core_done && core_res_n && !core_start && !in_ready && !out_valid;
            if (in_valid && in_ready) wcnt = (wcnt + 1) % 4;
         end
      end
   end

   initial begin
      forever begin
         tick();
         if (or_mode == 0) out_ready = ($urandom % 4) != 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] blk;
      int           guard;

      tick();
      tick();
      chk_reset_outputs("reset");
      res = 1'b0;
      tick();
      chk_en = 1'b1;

      load_cfg(rnd256(), 1'b0, 128'd0);
      for (int b = 0; b < 12; b++) begin
         int mode;
         mode = int'($urandom_range(0, 5));
         send_block(rnd128(), (mode == 1) ? 1 : ((mode == 2) ? 2 : 0));
      end
      drain();
      chk("cfg_key_kept", core_keys, m_key);
      chk("cfg_dec_kept", 256'(core_ctrl), 256'(m_dec));

      // Identical back-to-back blocks.
      blk = rnd128();
      send_block(blk, 0);
      send_block(blk, 0);
      drain();

      // Output back-pressure 1-0-0-1 with a mid-block config pulse.
      or_mode   = 1;
      out_ready = 1'b1;
      send_block(rnd128(), 2);
      guard = 0;
      while (!out_valid && guard < 300) begin
         tick();
         guard++;
      end
      if (!out_valid) tmo("out_valid_rise");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      tick();
      out_ready = 1'b1;
      drain();
      or_mode = 0;
      chk("key_after_midblock_cfg", core_keys, m_key);

      // Reset in WAIT.
      send_block(rnd128(), 0);
      guard = 0;
      while (!(core_res_n && !core_start && !in_ready && !out_valid) && guard < 300) begin
         tick();
         guard++;
      end
      if (!(core_res_n && !core_start && !in_ready && !out_valid)) tmo("reach_wait");
      chk_en = 1'b0;
      #2;
      res = 1'b1;
      #1;
      chk_reset_outputs("midwait_reset");
      exp_q.delete();
      m_key   = '0;
      m_dec   = 1'b0;
      m_chain = '0;
      tick();
      res = 1'b0;
      tick();
      chk_en = 1'b1;

      load_cfg(rnd256(), 1'b1, rnd128());
      for (int b = 0; b < 4; b++) send_block(rnd128(), (b == 2) ? 1 : 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
